// File: rtl/mano_io_pkg.sv
// Shared definitions for the Mano basic-computer I/O and interrupt unit.
//   DATA_W_DFLT : default width of AC/INPR/OUTR
//   FGI_RST     : input flag value after reset (no byte held)
//   FGO_RST     : output flag value after reset (channel ready)
//   out_state_e : output-channel state; FGO is high exactly in OutReady
package mano_io_pkg;

    localparam int unsigned DATA_W_DFLT = 8;

    localparam logic FGI_RST = 1'b0;
    localparam logic FGO_RST = 1'b1;

    typedef enum logic [0:0] {
        OutReady   = 1'b0,
        OutPending = 1'b1
    } out_state_e;

endpackage

// File: rtl/mano_io_out_chan.sv
// Output channel: holds OUTR and FGO and runs the handshake with the output device.
// Ports:
//   CLK, RST_N       clock, asynchronous active-low reset
//   ac_in            core AC value, captured on out_exec
//   out_exec         core executes OUT this cycle
//   out_ready        output device accepts out_data
//   out_data         OUTR contents
//   out_valid        OUTR holds an undelivered byte (= ~FGO)
//   fgo              output flag
module mano_io_out_chan
    import mano_io_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DFLT
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] ac_in,
    input  logic              out_exec,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              fgo
);

    out_state_e        state_q;
    logic [DATA_W-1:0] outr_q;

    // A new OUT takes priority over a same-cycle delivery: the fresh byte stays pending.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= (FGO_RST == 1'b1) ? OutReady : OutPending;
            outr_q  <= '0;
        end else begin
            if (out_exec) begin
                outr_q  <= ac_in;
                state_q <= OutPending;
            end else if (state_q == OutPending && out_ready) begin
                state_q <= OutReady;
            end
        end
    end

    assign out_data  = outr_q;
    assign out_valid = (state_q == OutPending);
    assign fgo       = (state_q == OutReady);

endmodule

// File: rtl/mano_io_unit.sv
// I/O and interrupt front end for the 8-bit Mano basic computer.
// Holds INPR/FGI (input side), OUTR/FGO via mano_io_out_chan (output side),
// IEN and the interrupt flip-flop R sampled by the core.
// Optional macro MANO_IO_OVERRUN_EN adds sticky overrun flags in_ovr/out_ovr
// and their clear input ovr_clr.
// Ports:
//   CLK, RST_N                     clock, asynchronous active-low reset
//   in_data/in_valid/in_ready      input device handshake (in_ready = ~FGI)
//   out_data/out_valid/out_ready   output device handshake (out_valid = ~FGO)
//   ac_in                          core AC value for OUT
//   inp_exec, out_exec             core executes INP / OUT
//   ski_exec, sko_exec             core executes SKI / SKO
//   ion_exec, iof_exec             core executes ION / IOF
//   t_idle                         core is outside T0..T2
//   int_ack                        core completes its interrupt cycle
//   inpr                           INPR, for the AC load on INP
//   skip                           combinational skip condition
//   fgi, fgo, ien, irq             flag state, irq = R
module mano_io_unit
    import mano_io_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DFLT
) (
    input  logic              CLK,
    input  logic              RST_N,
`ifdef MANO_IO_OVERRUN_EN
    input  logic              ovr_clr,
    output logic              in_ovr,
    output logic              out_ovr,
`endif
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [DATA_W-1:0] ac_in,
    input  logic              inp_exec,
    input  logic              out_exec,
    input  logic              ski_exec,
    input  logic              sko_exec,
    input  logic              ion_exec,
    input  logic              iof_exec,
    input  logic              t_idle,
    input  logic              int_ack,
    output logic [DATA_W-1:0] inpr,
    output logic              skip,
    output logic              fgi,
    output logic              fgo,
    output logic              ien,
    output logic              irq
);

    logic [DATA_W-1:0] inpr_q, inpr_d;
    logic              fgi_q, fgi_d;
    logic              ien_q, ien_d;
    logic              r_q, r_d;
    logic              fgo_w;
    logic              accept;

    mano_io_out_chan #(
        .DATA_W (DATA_W)
    ) u_out_chan (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ac_in     (ac_in),
        .out_exec  (out_exec),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .fgo       (fgo_w)
    );

    // in_ready comes from the flag register only, so in_valid never loops back to it.
    assign accept = in_valid & ~fgi_q;

    always_comb begin
        inpr_d = inpr_q;
        fgi_d  = fgi_q;
        ien_d  = ien_q;
        r_d    = r_q;

        // An accept wins over a same-cycle INP, leaving the new byte flagged.
        if (accept) begin
            inpr_d = in_data;
            fgi_d  = 1'b1;
        end else if (inp_exec) begin
            fgi_d = 1'b0;
        end

        if (int_ack) begin
            ien_d = 1'b0;
        end else if (iof_exec) begin
            ien_d = 1'b0;
        end else if (ion_exec) begin
            ien_d = 1'b1;
        end

        // R is sticky until the core acknowledges, even if the flags drop.
        if (int_ack) begin
            r_d = 1'b0;
        end else if (t_idle && ien_q && (fgi_q || fgo_w)) begin
            r_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            inpr_q <= '0;
            fgi_q  <= FGI_RST;
            ien_q  <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            inpr_q <= inpr_d;
            fgi_q  <= fgi_d;
            ien_q  <= ien_d;
            r_q    <= r_d;
        end
    end

`ifdef MANO_IO_OVERRUN_EN
    logic in_ovr_q, in_ovr_d;
    logic out_ovr_q, out_ovr_d;

    // Set takes priority over a same-cycle clear.
    always_comb begin
        in_ovr_d  = in_ovr_q;
        out_ovr_d = out_ovr_q;
        if (in_valid && fgi_q) begin
            in_ovr_d = 1'b1;
        end else if (ovr_clr) begin
            in_ovr_d = 1'b0;
        end
        if (out_exec && !fgo_w) begin
            out_ovr_d = 1'b1;
        end else if (ovr_clr) begin
            out_ovr_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            in_ovr_q  <= 1'b0;
            out_ovr_q <= 1'b0;
        end else begin
            in_ovr_q  <= in_ovr_d;
            out_ovr_q <= out_ovr_d;
        end
    end

    assign in_ovr  = in_ovr_q;
    assign out_ovr = out_ovr_q;
`endif

    assign inpr     = inpr_q;
    assign fgi      = fgi_q;
    assign fgo      = fgo_w;
    assign ien      = ien_q;
    assign irq      = r_q;
    assign in_ready = ~fgi_q;
    assign skip     = (ski_exec & fgi_q) | (sko_exec & fgo_w);

endmodule

// File: tb/tb_mano_io_unit.sv
// Directed bench for mano_io_unit. Expected values are queued as stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_mano_io_unit;

    localparam int unsigned W = 8;

    logic         CLK;
    logic         RST_N;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ac_in;
    logic         inp_exec, out_exec, ski_exec, sko_exec;
    logic         ion_exec, iof_exec, t_idle, int_ack;
    logic [W-1:0] inpr;
    logic         skip, fgi, fgo, ien, irq;
`ifdef MANO_IO_OVERRUN_EN
    logic         ovr_clr, in_ovr, out_ovr;
`endif

    mano_io_unit #(
        .DATA_W (W)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
`ifdef MANO_IO_OVERRUN_EN
        .ovr_clr   (ovr_clr),
        .in_ovr    (in_ovr),
        .out_ovr   (out_ovr),
`endif
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ac_in     (ac_in),
        .inp_exec  (inp_exec),
        .out_exec  (out_exec),
        .ski_exec  (ski_exec),
        .sko_exec  (sko_exec),
        .ion_exec  (ion_exec),
        .iof_exec  (iof_exec),
        .t_idle    (t_idle),
        .int_ack   (int_ack),
        .inpr      (inpr),
        .skip      (skip),
        .fgi       (fgi),
        .fgo       (fgo),
        .ien       (ien),
        .irq       (irq)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0; ac_in = '0;
        inp_exec = 1'b0; out_exec = 1'b0; ski_exec = 1'b0; sko_exec = 1'b0;
        ion_exec = 1'b0; iof_exec = 1'b0; t_idle = 1'b0; int_ack = 1'b0;
`ifdef MANO_IO_OVERRUN_EN
        ovr_clr = 1'b0;
`endif
        #12;
        // Reset state
        push("rst_fgo", 1); push("rst_fgi", 0); push("rst_ien", 0); push("rst_irq", 0);
        push("rst_in_ready", 1); push("rst_out_valid", 0); push("rst_inpr", 0);
        push("rst_out_data", 0);
        pop_chk(fgo); pop_chk(fgi); pop_chk(ien); pop_chk(irq);
        pop_chk(in_ready); pop_chk(out_valid); pop_chk(inpr); pop_chk(out_data);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();

        // Input accept, SKI, INP
        in_data = 8'hA5; in_valid = 1'b1;
        push("acc_fgi", 1); push("acc_inpr", 8'hA5); push("acc_in_ready", 0);
        tick();
        in_valid = 1'b0;
        pop_chk(fgi); pop_chk(inpr); pop_chk(in_ready);
        ski_exec = 1'b1; push("ski_skip", 1); #1; pop_chk(skip);
        ski_exec = 1'b0;
        inp_exec = 1'b1; push("inp_fgi", 0); push("inp_inpr", 8'hA5);
        tick();
        inp_exec = 1'b0;
        pop_chk(fgi); pop_chk(inpr);
        ski_exec = 1'b1; push("ski_noskip", 0); #1; pop_chk(skip);
        ski_exec = 1'b0;

        // OUT with a stalled device, then delivery and SKO
        ac_in = 8'h3C; out_exec = 1'b1;
        tick();
        out_exec = 1'b0; ac_in = 8'h00;
        for (int i = 0; i < 3; i++) begin
            push("stall_valid", 1); push("stall_data", 8'h3C); push("stall_fgo", 0);
            pop_chk(out_valid); pop_chk(out_data); pop_chk(fgo);
            tick();
        end
        out_ready = 1'b1; push("dlv_fgo", 1); push("dlv_valid", 0);
        tick();
        out_ready = 1'b0;
        pop_chk(fgo); pop_chk(out_valid);
        sko_exec = 1'b1; push("sko_skip", 1); #1; pop_chk(skip);
        sko_exec = 1'b0;

        // IEN and R
        ion_exec = 1'b1; push("ion_ien", 1); push("ion_irq_early", 0);
        tick();
        ion_exec = 1'b0;
        pop_chk(ien); pop_chk(irq);
        t_idle = 1'b1; push("r_set", 1);
        tick();
        t_idle = 1'b0;
        pop_chk(irq);
        push("r_hold", 1); tick(); pop_chk(irq);
        int_ack = 1'b1; push("ack_irq", 0); push("ack_ien", 0);
        tick();
        int_ack = 1'b0;
        pop_chk(irq); pop_chk(ien);
        ion_exec = 1'b1; iof_exec = 1'b1; push("ion_iof_ien", 0);
        tick();
        iof_exec = 1'b0;
        pop_chk(ien);
        int_ack = 1'b1; push("ion_ack_ien", 0);
        tick();
        ion_exec = 1'b0; int_ack = 1'b0;
        pop_chk(ien);
        t_idle = 1'b1; push("r_no_ien", 0);
        tick();
        t_idle = 1'b0;
        pop_chk(irq);

        // OUT racing a delivery; accept racing INP
        ac_in = 8'h55; out_exec = 1'b1;
        tick();
        ac_in = 8'h11; out_ready = 1'b1;
        push("race_out_data", 8'h11); push("race_fgo", 0); push("race_valid", 1);
        tick();
        out_exec = 1'b0; out_ready = 1'b0;
        pop_chk(out_data); pop_chk(fgo); pop_chk(out_valid);
        out_ready = 1'b1; push("race_dlv_fgo", 1);
        tick();
        out_ready = 1'b0;
        pop_chk(fgo);
        in_data = 8'h5A; in_valid = 1'b1; inp_exec = 1'b1;
        push("race_fgi", 1); push("race_inpr", 8'h5A);
        tick();
        inp_exec = 1'b0;
        pop_chk(fgi); pop_chk(inpr);
        // Second offer while full: no capture
        in_data = 8'hC3; push("full_inpr", 8'h5A); push("full_fgi", 1);
        tick();
        in_valid = 1'b0;
        pop_chk(inpr); pop_chk(fgi);
`ifdef MANO_IO_OVERRUN_EN
        push("in_ovr_set", 1); pop_chk(in_ovr);
        push("in_ovr_hold", 1); tick(); pop_chk(in_ovr);
        ovr_clr = 1'b1; push("in_ovr_clr", 0);
        tick();
        ovr_clr = 1'b0;
        pop_chk(in_ovr);
        ac_in = 8'h21; out_exec = 1'b1; tick();
        ac_in = 8'h22; ovr_clr = 1'b1; push("out_ovr_set", 1); push("ovr_data", 8'h22);
        tick();
        out_exec = 1'b0; ovr_clr = 1'b0;
        pop_chk(out_ovr); pop_chk(out_data);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
`endif

        // Asynchronous reset while a byte is pending
        ac_in = 8'h77; out_exec = 1'b1;
        tick();
        out_exec = 1'b0;
        push("pre_rst_valid", 1); pop_chk(out_valid);
        #1;
        RST_N = 1'b0;
        push("arst_valid", 0); push("arst_fgo", 1); push("arst_data", 0);
        push("arst_fgi", 0); push("arst_inpr", 0);
        #1;
        pop_chk(out_valid); pop_chk(fgo); pop_chk(out_data); pop_chk(fgi); pop_chk(inpr);
        @(negedge CLK);
        RST_N = 1'b1;
        push("post_rst_valid", 0); push("post_rst_fgo", 1);
        tick();
        pop_chk(out_valid); pop_chk(fgo);
`ifdef MANO_IO_OVERRUN_EN
        push("rst_in_ovr", 0); push("rst_out_ovr", 0);
        pop_chk(in_ovr); pop_chk(out_ovr);
`endif

        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
